game_sequencer: RTL and testbench

Top-level game flow controller that sits directly downstream of the per-level blocks. It consumes a level's `win`/`lose` outputs and decides which level is active and when that level is held in reset. It also tracks lives and tells the VGA path which screen to show: title, play, level-clear, died, game-over or game-won. The game flow is title → levels 0..NUM_LEVELS-1 → game won, with each level restarted on death until lives run out.

---
 rtl/game_sequencer.sv | 154 +++++++++++++++
 tb/tb_game_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Top-level game flow controller: title, level load/play, clear/died banners, game over/won.
// Tracks lives and the active level, and holds the level blocks in reset outside play.
module game_sequencer #(
  parameter int unsigned NUM_LEVELS    = 3,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned BANNER_CYCLES = 50_000_000,
  parameter int unsigned LOAD_CYCLES   = 4,
  parameter int unsigned ARM_CYCLES    = 2
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       start_button,
  input  logic       level_win,
  input  logic       level_lose,
  output logic [1:0] level_select,
  output logic       level_reset_n,
  output logic [2:0] screen_mode,
  output logic [2:0] lives
);

  localparam int CNT_W = $clog2(BANNER_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_DONE    = CNT_W'(ARM_CYCLES);
  localparam logic [1:0]       LAST_LEVEL  = 2'(NUM_LEVELS - 1);

  localparam logic [2:0] MODE_TITLE = 3'd0;
  localparam logic [2:0] MODE_PLAY  = 3'd1;
  localparam logic [2:0] MODE_CLEAR = 3'd2;
  localparam logic [2:0] MODE_DIED  = 3'd3;
  localparam logic [2:0] MODE_OVER  = 3'd4;
  localparam logic [2:0] MODE_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_TITLE, S_LOAD, S_PLAY, S_CLEAR, S_DIED, S_OVER, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       level_q, level_d;
  logic [2:0]       lives_q, lives_d;
  logic [2:0]       sync_q;
  logic             rstn_q, rstn_d;
  logic [2:0]       mode_q, mode_d;
  logic             press;
  logic             armed;

  function automatic logic [2:0] mode_of(input state_e s);
    case (s)
      S_TITLE: mode_of = MODE_TITLE;
      S_LOAD:  mode_of = MODE_PLAY;
      S_PLAY:  mode_of = MODE_PLAY;
      S_CLEAR: mode_of = MODE_CLEAR;
      S_DIED:  mode_of = MODE_DIED;
      S_OVER:  mode_of = MODE_OVER;
      S_DONE:  mode_of = MODE_DONE;
      default: mode_of = MODE_TITLE;
    endcase
  endfunction

  // sync_q[1:0] resolve metastability; sync_q[2] is the previous settled value for edge detect.
  assign press = sync_q[2] & ~sync_q[1];
  assign armed = (cnt_q >= ARM_DONE);

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path leaves a latch behind.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    lives_d = lives_q;

    case (state_q)
      S_TITLE: begin
        if (press) begin
          level_d = '0;
          lives_d = 3'(START_LIVES);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) state_d = S_PLAY;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      S_PLAY: begin
        if (!armed) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (level_win) begin
          state_d = S_CLEAR;
        end else if (level_lose) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            state_d = S_DIED;
          end else begin
            lives_d = 3'd0;
            state_d = S_OVER;
          end
        end
      end
      S_CLEAR: begin
        if (cnt_q == BANNER_LAST) begin
          if (level_q == LAST_LEVEL) begin
            state_d = S_DONE;
          end else begin
            level_d = level_q + 2'd1;
            state_d = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIED: begin
        if (cnt_q == BANNER_LAST) state_d = S_LOAD;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_OVER, S_DONE: begin
        if (press) state_d = S_TITLE;
      end
      default: state_d = S_TITLE;
    endcase

    // One shared counter serves load, arm and banner timing; it restarts on every state entry.
    if (state_d != state_q) cnt_d = '0;

    rstn_d = (state_d == S_PLAY);
    mode_d = mode_of(state_d);
  end

  always_ff @(posedge vga_clock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= S_TITLE;
      cnt_q   <= '0;
      level_q <= '0;
      lives_q <= 3'(START_LIVES);
      sync_q  <= '0;
      rstn_q  <= 1'b0;
      mode_q  <= MODE_TITLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      lives_q <= lives_d;
      sync_q  <= {sync_q[1:0], start_button};
      rstn_q  <= rstn_d;
      mode_q  <= mode_d;
    end
  end

  assign level_select  = level_q;
  assign level_reset_n = rstn_q;
  assign screen_mode   = mode_q;
  assign lives         = lives_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: per-cycle stimulus/expected pairs are queued,
// then applied one clock at a time and compared against the registered outputs.
module tb_game_sequencer;

  localparam int BANNER = 8;

  typedef struct packed {
    logic [2:0] mode;
    logic [1:0] lvl;
    logic [2:0] lives;
    logic       rstn;
  } outs_t;

  typedef struct {
    logic [3:0] ins;  // {button, win, lose, reset}
    outs_t      exp;
  } step_t;

  localparam logic [3:0] IDLE     = 4'b1000;
  localparam logic [3:0] PRESS    = 4'b0000;
  localparam logic [3:0] WIN      = 4'b1100;
  localparam logic [3:0] LOSE     = 4'b1010;
  localparam logic [3:0] BOTH     = 4'b1110;
  localparam logic [3:0] RST      = 4'b1001;
  localparam logic [3:0] RST_HELD = 4'b0001;

  logic       vga_clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_button = 1'b1;
  logic       level_win = 1'b0;
  logic       level_lose = 1'b0;
  logic [1:0] level_select;
  logic       level_reset_n;
  logic [2:0] screen_mode;
  logic [2:0] lives;

  int total = 0;
  int bad = 0;
  step_t sb[$];

  game_sequencer #(
    .NUM_LEVELS(3), .START_LIVES(3), .BANNER_CYCLES(BANNER), .LOAD_CYCLES(4), .ARM_CYCLES(2)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .start_button(start_button),
    .level_win(level_win), .level_lose(level_lose), .level_select(level_select),
    .level_reset_n(level_reset_n), .screen_mode(screen_mode), .lives(lives)
  );

  always #5 vga_clock = ~vga_clock;

  function automatic outs_t o(input int m, input int l, input int v, input bit r);
    o = '{mode: 3'(m), lvl: 2'(l), lives: 3'(v), rstn: r};
  endfunction

  function automatic outs_t observe();
    observe = {screen_mode, level_select, lives, level_reset_n};
  endfunction

  function automatic string fmt(input outs_t x);
    fmt = $sformatf("mode=%0d lvl=%0d lives=%0d rstn=%0b", x.mode, x.lvl, x.lives, x.rstn);
  endfunction

  task automatic add(input int n, input logic [3:0] ins, input outs_t exp);
    for (int i = 0; i < n; i++) sb.push_back('{ins: ins, exp: exp});
  endtask

  task automatic apply(input logic [3:0] ins);
    start_button = ins[3];
    level_win    = ins[2];
    level_lose   = ins[1];
    reset        = ins[0];
  endtask

  // LOAD entry edge already queued by the caller; 3 more LOAD cycles, PLAY entry, 2 arm cycles.
  task automatic push_load_play(input int lvl, input int lv);
    add(3, IDLE, o(1, lvl, lv, 0));
    add(3, IDLE, o(1, lvl, lv, 1));
  endtask

  task automatic test_reset();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(2, RST, o(0, 0, 3, 0));
    add(4, IDLE, o(0, 0, 3, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL reset step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_start();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(2, PRESS, o(0, 0, 3, 0));
    add(1, PRESS, o(1, 0, 3, 0));
    push_load_play(0, 3);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL start step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_win_levels();
    step_t s;
    outs_t obs;
    int idx = 0;
    for (int l = 0; l < 3; l++) begin
      add(1, WIN, o(2, l, 3, 0));
      add(BANNER - 1, IDLE, o(2, l, 3, 0));
      if (l < 2) begin
        add(1, IDLE, o(1, l + 1, 3, 0));
        push_load_play(l + 1, 3);
      end else begin
        add(4, IDLE, o(5, 2, 3, 0));
      end
    end
    add(2, PRESS, o(5, 2, 3, 0));
    add(1, PRESS, o(0, 2, 3, 0));
    add(3, PRESS, o(0, 2, 3, 0));
    add(3, IDLE, o(0, 2, 3, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL win_levels step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_lose();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(2, PRESS, o(0, 2, 3, 0));
    add(1, PRESS, o(1, 0, 3, 0));
    push_load_play(0, 3);
    add(1, WIN, o(2, 0, 3, 0));
    add(BANNER - 1, IDLE, o(2, 0, 3, 0));
    add(1, IDLE, o(1, 1, 3, 0));
    push_load_play(1, 3);
    for (int lv = 3; lv >= 2; lv--) begin
      add(1, LOSE, o(3, 1, lv - 1, 0));
      add(BANNER - 1, IDLE, o(3, 1, lv - 1, 0));
      add(1, IDLE, o(1, 1, lv - 1, 0));
      push_load_play(1, lv - 1);
    end
    add(1, LOSE, o(4, 1, 0, 0));
    add(3, LOSE, o(4, 1, 0, 0));
    add(2, PRESS, o(4, 1, 0, 0));
    add(1, PRESS, o(0, 1, 0, 0));
    add(3, IDLE, o(0, 1, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL lose step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_win_lose_same();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(2, PRESS, o(0, 1, 0, 0));
    add(1, PRESS, o(1, 0, 3, 0));
    push_load_play(0, 3);
    add(1, BOTH, o(2, 0, 3, 0));
    add(BANNER - 1, IDLE, o(2, 0, 3, 0));
    add(4, IDLE, o(1, 1, 3, 0));
    add(1, IDLE, o(1, 1, 3, 1));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL win_lose_same step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_arm();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(1, BOTH, o(1, 1, 3, 1));
    add(1, LOSE, o(1, 1, 3, 1));
    add(1, LOSE, o(3, 1, 2, 0));
    add(BANNER - 1, IDLE, o(3, 1, 2, 0));
    add(1, IDLE, o(1, 1, 2, 0));
    push_load_play(1, 2);
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL arm step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    outs_t obs;
    int idx = 0;
    add(1, WIN, o(2, 1, 2, 0));
    add(5, IDLE, o(2, 1, 2, 0));
    add(2, RST_HELD, o(0, 0, 3, 0));
    add(6, PRESS, o(0, 0, 3, 0));
    add(3, IDLE, o(0, 0, 3, 0));
    add(2, PRESS, o(0, 0, 3, 0));
    add(1, PRESS, o(1, 0, 3, 0));
    add(3, IDLE, o(1, 0, 3, 0));
    add(1, IDLE, o(1, 0, 3, 1));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s.ins);
      @(posedge vga_clock); #1;
      obs = observe();
      total++;
      if (obs !== s.exp) begin
        bad++;
        $display("FAIL reset_mid step %0d: got %s, want %s", idx, fmt(obs), fmt(s.exp));
      end
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_win_levels();
    test_lose();
    test_win_lose_same();
    test_arm();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
